pipeline_stall_ctrl: RTL and testbench

- Consumer side of the hazard-detection stall request in the 5-stage, 4-bit-opcode pipeline.
- Merges the load-use stall, control-flow flushes, the data-memory wait and HALT into per-stage write-enable and flush strobes for PC, IF/ID, ID/EX and EX/MEM.
- Owns a small RUN/DRAIN/HALTED FSM and saturating stall/flush performance counters.
- Sits between the hazard detection unit and the pipeline registers.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 21 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 28 ++
 rtl/pipeline_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg : shared state, PC-select and opcode encodings
// Revision 1.0
// ---------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;

    localparam logic [3:0] OP_HALT = 4'd15;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : increment-only counter that sticks at all-ones
// Revision 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl : merges stall/flush/halt/memory-wait into stage strobes
// Revision 1.0
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hd_stall,
    input  logic             br_taken_ex,
    input  logic             jump_id,
    input  logic             halt_id,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] c_drainLoad = DW'(DRAIN_CYC - 1);

    state_t        r_state;
    logic [DW-1:0] r_drainCnt;
    logic          w_stallInc;
    logic          w_flushInc;
    logic          w_haltTake;

    always_comb begin
        pc_we      = 1'b1;
        pc_sel     = PCSEL_SEQ;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_we   = 1'b1;
        w_stallInc = 1'b0;
        w_flushInc = 1'b0;
        w_haltTake = 1'b0;
        case (r_state)
            RUN: begin
                if (mem_busy) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    exmem_we = 1'b0;
                end else if (br_taken_ex) begin
                    pc_sel     = PCSEL_BR;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    w_flushInc = 1'b1;
                end else if (jump_id) begin
                    pc_sel     = PCSEL_JMP;
                    ifid_flush = 1'b1;
                    w_flushInc = 1'b1;
                end else if (halt_id) begin
                    // HALT itself still moves into ID/EX; only fetch stops
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    w_haltTake = 1'b1;
                end else if (hd_stall) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    w_stallInc = 1'b1;
                end
            end
            DRAIN: begin
                pc_we      = 1'b0;
                ifid_we    = !mem_busy;
                ifid_flush = 1'b1;
                exmem_we   = !mem_busy;
            end
            default: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                exmem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_drainCnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_haltTake) begin
                        r_state    <= DRAIN;
                        r_drainCnt <= c_drainLoad;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (r_drainCnt == '0) begin
                            r_state <= HALTED;
                        end else begin
                            r_drainCnt <= r_drainCnt - 1'b1;
                        end
                    end
                end
                default: r_state <= HALTED;
            endcase
        end
    end

    assign halted = (r_state == HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stallInc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flushInc),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl : scoreboard bench for pipeline_stall_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 4;
    localparam logic [1:0] M_RUN = 2'd0, M_DRAIN = 2'd1, M_HALTED = 2'd2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hd_stall, br_taken_ex, jump_id, halt_id, mem_busy;
    logic             pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, halted;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb[$];

    logic [1:0]       mstate;
    logic [1:0]       mdrain;
    logic [CNT_W-1:0] mstall, mflush;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hd_stall    (hd_stall),
        .br_taken_ex (br_taken_ex),
        .jump_id     (jump_id),
        .halt_id     (halt_id),
        .mem_busy    (mem_busy),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_we    (exmem_we),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] got();
        return {pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, exmem_we, halted,
                stall_cnt, flush_cnt};
    endfunction

    // Reference behaviour written from the priority table, not from the RTL
    function automatic logic [15:0] model_out();
        logic pw = 1'b1, iw = 1'b1, ifl = 1'b0, idf = 1'b0, ew = 1'b1, hl = 1'b0;
        logic [1:0] ps = 2'd0;
        if (mstate == M_RUN) begin
            if (mem_busy) begin pw = 0; iw = 0; ew = 0; end
            else if (br_taken_ex) begin ps = 2'd1; ifl = 1; idf = 1; end
            else if (jump_id) begin ps = 2'd2; ifl = 1; end
            else if (halt_id) begin pw = 0; ifl = 1; end
            else if (hd_stall) begin pw = 0; iw = 0; idf = 1; end
        end else if (mstate == M_DRAIN) begin
            pw = 0; iw = !mem_busy; ifl = 1; ew = !mem_busy;
        end else begin
            pw = 0; iw = 0; ew = 0; hl = 1;
        end
        return {pw, ps, iw, ifl, idf, ew, hl, mstall, mflush};
    endfunction

    task automatic model_step();
        if (mstate == M_RUN && !mem_busy) begin
            if (br_taken_ex || jump_id) begin
                if (mflush != 4'hF) mflush = mflush + 4'd1;
            end else if (halt_id) begin
                mstate = M_DRAIN;
                mdrain = 2'd2;
            end else if (hd_stall) begin
                if (mstall != 4'hF) mstall = mstall + 4'd1;
            end
        end else if (mstate == M_DRAIN && !mem_busy) begin
            if (mdrain == 2'd0) mstate = M_HALTED;
            else mdrain = mdrain - 2'd1;
        end
    endtask

    task automatic model_reset();
        mstate = M_RUN; mdrain = 2'd0; mstall = '0; mflush = '0;
    endtask

    // Advance one cycle, apply new inputs, record expectation, stop at negedge
    task automatic drive(input logic st, input logic br, input logic jp,
                         input logic ht, input logic mb);
        @(posedge clk);
        model_step();
        #1;
        hd_stall = st; br_taken_ex = br; jump_id = jp; halt_id = ht; mem_busy = mb;
        sb.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        rst_n = 1'b0;
        hd_stall = 0; br_taken_ex = 0; jump_id = 0; halt_id = 0; mem_busy = 0;
        model_reset();
        repeat (2) @(negedge clk);
        sb.push_back(16'b1_00_1_0_0_1_0_0000_0000);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got(), exp);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [15:0] exp;
        drive(1, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL load_use_bubble got=%h exp=%h", got(), exp);
        end
        drive(0, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp || stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_use_after got=%h exp=%h stall_cnt=%0d", got(), exp, stall_cnt);
        end
    endtask

    task automatic test_branch_priority();
        logic [15:0] exp;
        drive(1, 1, 1, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL branch_priority got=%h exp=%h", got(), exp);
        end
        drive(0, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp || flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL branch_counts got=%h exp=%h", got(), exp);
        end
    endtask

    task automatic test_jump();
        logic [15:0] exp;
        drive(1, 0, 1, 1, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL jump_over_halt got=%h exp=%h", got(), exp);
        end
        drive(0, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp || flush_cnt !== 4'd2) begin
            failures++;
            $display("FAIL jump_counts got=%h exp=%h", got(), exp);
        end
    endtask

    task automatic test_mem_freeze();
        logic [15:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 1);
            exp = sb.pop_front();
            checks++;
            if (got() !== exp) begin
                failures++;
                $display("FAIL mem_freeze[%0d] got=%h exp=%h", i, got(), exp);
            end
        end
        drive(1, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL freeze_release got=%h exp=%h", got(), exp);
        end
        drive(0, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp || stall_cnt !== 4'd2) begin
            failures++;
            $display("FAIL freeze_once got=%h exp=%h", got(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0);
            exp = sb.pop_front();
            checks++;
            if (got() !== exp) begin
                failures++;
                $display("FAIL stall_held[%0d] got=%h exp=%h", i, got(), exp);
            end
        end
        drive(0, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp || stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL saturation got=%h exp=%h stall_cnt=%0d", got(), exp, stall_cnt);
        end
    endtask

    task automatic test_halt_drain();
        logic [15:0] exp;
        logic [4:0]  busyPat;
        busyPat = 5'b01100;
        drive(0, 0, 0, 1, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL halt_issue got=%h exp=%h", got(), exp);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 1, busyPat[4-i]);
            exp = sb.pop_front();
            checks++;
            if (got() !== exp || pc_we !== 1'b0 || halted !== 1'b0) begin
                failures++;
                $display("FAIL drain[%0d] got=%h exp=%h", i, got(), exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1, i[1], 1, 0);
            exp = sb.pop_front();
            checks++;
            if (got() !== exp || halted !== 1'b1) begin
                failures++;
                $display("FAIL halted[%0d] got=%h exp=%h", i, got(), exp);
            end
        end
    endtask

    task automatic test_async_reset_halted();
        logic [15:0] exp;
        @(negedge clk);
        hd_stall = 0; br_taken_ex = 0; jump_id = 0; halt_id = 0; mem_busy = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            failures++;
            $display("FAIL async_reset got halted=%b stall=%0d flush=%0d exp 0/0/0",
                     halted, stall_cnt, flush_cnt);
        end
        #1 rst_n = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0);
        exp = sb.pop_front();
        checks++;
        if (got() !== exp || pc_we !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_run got=%h exp=%h", got(), exp);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_jump();
        test_mem_freeze();
        test_back_to_back();
        test_halt_drain();
        test_async_reset_halted();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
